// File: rtl/remind_alarm.sv
// remind_alarm: reminder alert controller with debounced ack/snooze buttons,
// escalation after an unanswered alert, and a saturating escalation counter.
//   clk          - system clock, rising edge
//   reset        - asynchronous active-high reset
//   remind       - reminder level from upstream timer (rising edge starts alert)
//   ack_n        - raw active-low acknowledge button
//   snooze_n     - raw active-low snooze button
//   buzzer       - piezo drive
//   led          - alert indicator
//   alert_active - high whenever the controller is not idle
//   missed_count - number of escalations, saturating at 15
module remind_alarm #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned BEEP_DIV   = 25_000,
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned ESC_SEC    = 60,
    parameter int unsigned SNOOZE_SEC = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       remind,
    input  logic       ack_n,
    input  logic       snooze_n,
    output logic       buzzer,
    output logic       led,
    output logic       alert_active,
    output logic [3:0] missed_count
);

    localparam int unsigned TW      = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
    localparam int unsigned BW      = (BEEP_DIV > 1)   ? $clog2(BEEP_DIV)   : 1;
    localparam int unsigned DW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned SEC_MAX = (ESC_SEC > SNOOZE_SEC) ? ESC_SEC : SNOOZE_SEC;
    localparam int unsigned SW      = $clog2(SEC_MAX + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ALERT    = 2'd1;
    localparam logic [1:0] ST_SNOOZE   = 2'd2;
    localparam logic [1:0] ST_ESCALATE = 2'd3;

    // Button bit 0 is ack, bit 1 is snooze.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         deb_q, deb_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;

    logic               remind_q;
    logic [1:0]         state_q, state_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]      sec_q, sec_d;
    logic [BW-1:0]      beep_cnt_q, beep_cnt_d;
    logic               tone_q, tone_d;
    logic               beat_q, beat_d;
    logic [3:0]         missed_q, missed_d;
    logic               buzzer_q, buzzer_d;
    logic               led_q, led_d;
    logic               active_q, active_d;

    logic ack_ev, snz_ev, rem_ev, tick, esc_due, snz_due, moved;

    assign ack_ev  = press_q[0];
    assign snz_ev  = press_q[1];
    assign rem_ev  = remind & ~remind_q;
    assign tick    = (tick_cnt_q == TW'(TICK_DIV - 1));
    // Timeouts fire on the tick that brings the second counter to its limit.
    assign esc_due = tick && (sec_q == SW'(ESC_SEC - 1));
    assign snz_due = tick && (sec_q == SW'(SNOOZE_SEC - 1));

    // Debouncers: accept a new level after DEB_CYCLES differing samples in a row.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        press_d   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
                press_d[i]   = ~sync2_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    // Next-state logic; ack beats snooze beats timeout.
    always_comb begin
        state_d  = state_q;
        missed_d = missed_q;
        case (state_q)
            ST_IDLE: begin
                if (rem_ev) state_d = ST_ALERT;
            end
            ST_ALERT: begin
                if (ack_ev) begin
                    state_d = ST_IDLE;
                end else if (snz_ev) begin
                    state_d = ST_SNOOZE;
                end else if (esc_due) begin
                    state_d = ST_ESCALATE;
                    if (missed_q != 4'd15) missed_d = missed_q + 4'd1;
                end
            end
            ST_SNOOZE: begin
                if (ack_ev)       state_d = ST_IDLE;
                else if (snz_due) state_d = ST_ALERT;
            end
            ST_ESCALATE: begin
                if (ack_ev)      state_d = ST_IDLE;
                else if (snz_ev) state_d = ST_SNOOZE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timebase: tick/second/beat restart on every state change, tone free-runs.
    always_comb begin
        moved      = (state_d != state_q);
        tick_cnt_d = tick_cnt_q + TW'(1);
        sec_d      = sec_q;
        beat_d     = beat_q;
        beep_cnt_d = beep_cnt_q + BW'(1);
        tone_d     = tone_q;
        if (tick) begin
            tick_cnt_d = '0;
            sec_d      = sec_q + SW'(1);
            beat_d     = ~beat_q;
        end
        if (moved) begin
            tick_cnt_d = '0;
            sec_d      = '0;
            beat_d     = 1'b1;
        end
        if (beep_cnt_q == BW'(BEEP_DIV - 1)) begin
            beep_cnt_d = '0;
            tone_d     = ~tone_q;
        end
    end

    // Output decode from next-cycle state so the registered outputs track state_q.
    always_comb begin
        buzzer_d = 1'b0;
        led_d    = 1'b0;
        active_d = (state_d != ST_IDLE);
        case (state_d)
            ST_ALERT: begin
                led_d    = 1'b1;
                buzzer_d = tone_d & beat_d;
            end
            ST_SNOOZE: begin
                led_d    = beat_d;
            end
            ST_ESCALATE: begin
                led_d    = 1'b1;
                buzzer_d = tone_d;
            end
            default: begin
                led_d    = 1'b0;
                buzzer_d = 1'b0;
            end
        endcase
    end

    // State registers; buttons reset to the released level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            deb_q      <= 2'b11;
            deb_cnt_q  <= '0;
            press_q    <= 2'b00;
            remind_q   <= 1'b0;
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            sec_q      <= '0;
            beep_cnt_q <= '0;
            tone_q     <= 1'b0;
            beat_q     <= 1'b0;
            missed_q   <= 4'd0;
            buzzer_q   <= 1'b0;
            led_q      <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            sync1_q    <= {snooze_n, ack_n};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            press_q    <= press_d;
            remind_q   <= remind;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            sec_q      <= sec_d;
            beep_cnt_q <= beep_cnt_d;
            tone_q     <= tone_d;
            beat_q     <= beat_d;
            missed_q   <= missed_d;
            buzzer_q   <= buzzer_d;
            led_q      <= led_d;
            active_q   <= active_d;
        end
    end

    assign buzzer       = buzzer_q;
    assign led          = led_q;
    assign alert_active = active_q;
    assign missed_count = missed_q;

endmodule

// File: tb/tb_remind_alarm.sv
// Bench for remind_alarm: a behavioural model predicts every output each
// cycle into a scoreboard queue, plus directed checks of the scenario timings.
module tb_remind_alarm;

    localparam int TICK   = 10;
    localparam int BEEP   = 2;
    localparam int DEB    = 3;
    localparam int ESC    = 3;
    localparam int SNOOZE = 4;

    typedef struct packed {
        logic       buz;
        logic       led;
        logic       act;
        logic [3:0] missed;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       remind = 1'b0;
    logic       ack_n = 1'b1;
    logic       snooze_n = 1'b1;
    logic       buzzer, led, alert_active;
    logic [3:0] missed_count;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    remind_alarm #(
        .TICK_DIV  (TICK),
        .BEEP_DIV  (BEEP),
        .DEB_CYCLES(DEB),
        .ESC_SEC   (ESC),
        .SNOOZE_SEC(SNOOZE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .remind      (remind),
        .ack_n       (ack_n),
        .snooze_n    (snooze_n),
        .buzzer      (buzzer),
        .led         (led),
        .alert_active(alert_active),
        .missed_count(missed_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model: state tracked as cycles-since-entry rather than counters.
    logic [1:0] m_s1 = 2'b11, m_s2 = 2'b11, m_last = 2'b11, m_db = 2'b11, m_ev = 2'b00;
    int         m_run [2];
    logic       m_rprev = 1'b0;
    int         m_state = 0, m_k = 0, m_c = 0, m_missed = 0;
    int         n_run [2];
    logic [1:0] n_db, n_ev;
    int         ns, nk, nc, nmiss;
    logic       m_ack, m_snz, m_rem, m_tone, m_beat;
    exp_t       e_push;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 <= 2'b11; m_s2 <= 2'b11; m_last <= 2'b11; m_db <= 2'b11; m_ev <= 2'b00;
            m_run[0] <= 0; m_run[1] <= 0;
            m_rprev <= 1'b0; m_state <= 0; m_k <= 0; m_c <= 0; m_missed <= 0;
            e_push = '0;
        end else begin
            n_db = m_db;
            n_ev = 2'b00;
            for (int i = 0; i < 2; i++) begin
                n_run[i] = (m_run[i] > 0 && m_s2[i] == m_last[i]) ? m_run[i] + 1 : 1;
                if (n_run[i] >= DEB && m_s2[i] != m_db[i]) begin
                    n_db[i] = m_s2[i];
                    n_ev[i] = ~m_s2[i];
                end
            end
            m_ack = m_ev[0];
            m_snz = m_ev[1];
            m_rem = remind && !m_rprev;
            ns    = m_state;
            nmiss = m_missed;
            case (m_state)
                0: if (m_rem) ns = 1;
                1: begin
                    if (m_ack) ns = 0;
                    else if (m_snz) ns = 2;
                    else if (m_k == ESC * TICK - 1) begin
                        ns    = 3;
                        nmiss = (m_missed < 15) ? m_missed + 1 : 15;
                    end
                end
                2: if (m_ack) ns = 0; else if (m_k == SNOOZE * TICK - 1) ns = 1;
                default: if (m_ack) ns = 0; else if (m_snz) ns = 2;
            endcase
            nk     = (ns != m_state) ? 0 : m_k + 1;
            nc     = m_c + 1;
            m_tone = ((nc / BEEP) % 2) == 1;
            m_beat = ((nk / TICK) % 2) == 0;
            e_push.act    = (ns != 0);
            e_push.led    = (ns == 1) || (ns == 3) || (ns == 2 && m_beat);
            e_push.buz    = (ns == 1 && m_tone && m_beat) || (ns == 3 && m_tone);
            e_push.missed = 4'(nmiss);
            m_s1 <= {snooze_n, ack_n};
            m_s2 <= m_s1;
            m_last <= m_s2;
            m_run[0] <= n_run[0];
            m_run[1] <= n_run[1];
            m_db <= n_db;
            m_ev <= n_ev;
            m_rprev <= remind;
            m_state <= ns;
            m_k <= nk;
            m_c <= nc;
            m_missed <= nmiss;
        end
        exp_q.push_back(e_push);
    end

    // Scoreboard compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("sb_buzzer", 32'(buzzer), 32'(e.buz));
            check_eq("sb_led", 32'(led), 32'(e.led));
            check_eq("sb_active", 32'(alert_active), 32'(e.act));
            check_eq("sb_missed", 32'(missed_count), 32'(e.missed));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic remind_edge();
        remind = 1'b0;
        cyc(1);
        remind = 1'b1;
        cyc(1);
    endtask

    task automatic press_ack();
        ack_n = 1'b0;
        cyc(8);
        ack_n = 1'b1;
        cyc(8);
    endtask

    initial begin
        int trans, ones;
        logic prev;

        cyc(3);
        check_eq("rst_buzzer", 32'(buzzer), 0);
        check_eq("rst_led", 32'(led), 0);
        check_eq("rst_active", 32'(alert_active), 0);
        check_eq("rst_missed", 32'(missed_count), 0);
        reset = 1'b0;
        cyc(5);

        // Alert entry one cycle after the remind edge; beep then silence.
        remind_edge();
        remind = 1'b0;
        check_eq("alert_active", 32'(alert_active), 1);
        check_eq("alert_led", 32'(led), 1);
        trans = 0;
        prev  = buzzer;
        for (int i = 0; i < 10; i++) begin
            if (buzzer != prev) trans++;
            prev = buzzer;
            cyc(1);
        end
        check_eq("alert_beep_toggles", 32'(trans >= 4), 1);
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            if (buzzer) ones++;
            cyc(1);
        end
        check_eq("alert_quiet_half", 32'(ones), 0);
        press_ack();
        check_eq("ack_to_idle", 32'(alert_active), 0);
        check_eq("no_escalation_yet", 32'(missed_count), 0);

        // Repeated unanswered alerts escalate; counter saturates at 15.
        for (int i = 0; i < 17; i++) begin
            remind_edge();
            cyc(30);
            check_eq("esc_led", 32'(led), 1);
            check_eq("esc_missed", 32'(missed_count), 32'((i + 1 > 15) ? 15 : i + 1));
            if (i == 0) begin
                trans = 0;
                prev  = buzzer;
                for (int j = 0; j < 8; j++) begin
                    cyc(1);
                    if (buzzer != prev) trans++;
                    prev = buzzer;
                end
                check_eq("esc_tone_toggles", 32'(trans >= 3), 1);
            end
            press_ack();
            check_eq("esc_ack_idle", 32'(alert_active), 0);
        end
        remind = 1'b0;

        // Snooze hold, ignored ack glitch and remind, then return to alert.
        remind_edge();
        remind = 1'b0;
        snooze_n = 1'b0;
        cyc(10);
        snooze_n = 1'b1;
        check_eq("snooze_active", 32'(alert_active), 1);
        check_eq("snooze_silent", 32'(buzzer), 0);
        ack_n = 1'b0;
        cyc(2);
        ack_n = 1'b1;
        remind = 1'b1;
        cyc(1);
        remind = 1'b0;
        cyc(7);
        check_eq("glitch_rejected", 32'(alert_active), 1);
        check_eq("snooze_led_beat", 32'(led), 0);
        cyc(26);
        check_eq("snooze_back_alert", 32'(led), 1);
        check_eq("snooze_back_active", 32'(alert_active), 1);
        press_ack();
        check_eq("snooze_ack_idle", 32'(alert_active), 0);

        // Simultaneous ack and snooze in escalation: ack wins.
        remind_edge();
        remind = 1'b0;
        cyc(30);
        check_eq("esc2_missed", 32'(missed_count), 15);
        ack_n    = 1'b0;
        snooze_n = 1'b0;
        cyc(10);
        check_eq("ack_beats_snooze", 32'(alert_active), 0);
        ack_n    = 1'b1;
        snooze_n = 1'b1;
        cyc(8);

        // Reset mid-snooze with both buttons held low.
        remind_edge();
        remind = 1'b0;
        snooze_n = 1'b0;
        cyc(10);
        check_eq("pre_rst_snooze", 32'(alert_active), 1);
        ack_n = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rst_now_buzzer", 32'(buzzer), 0);
        check_eq("rst_now_active", 32'(alert_active), 0);
        check_eq("rst_now_missed", 32'(missed_count), 0);
        cyc(3);
        reset = 1'b0;
        cyc(30);
        check_eq("post_rst_active", 32'(alert_active), 0);
        check_eq("post_rst_led", 32'(led), 0);
        check_eq("post_rst_buzzer", 32'(buzzer), 0);
        ack_n    = 1'b1;
        snooze_n = 1'b1;
        cyc(10);
        check_eq("final_idle", 32'(alert_active), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/remind_alarm.md
REMIND_ALARM -- requirements
Module: remind_alarm

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000; clk cycles per 1 s tick.
REQ-002 SHALL have parameter BEEP_DIV, default 25_000; clk cycles per tone half-period (1 kHz at 50 MHz).
REQ-003 SHALL have parameter DEB_CYCLES, default 1_000_000; consecutive stable cycles to accept a button level (20 ms).
REQ-004 SHALL have parameter ESC_SEC, default 60; ticks in ALERT before escalation.
REQ-005 SHALL have parameter SNOOZE_SEC, default 300; ticks spent in SNOOZE.
REQ-006 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port remind  input  1  reminder level from the upstream timer, synchronous to clk.
REQ-009 SHALL have port ack_n  input  1  raw active-low acknowledge push-button.
REQ-010 SHALL have port snooze_n  input  1  raw active-low snooze push-button.
REQ-011 SHALL have port buzzer  output  1  piezo drive.
REQ-012 SHALL have port led  output  1  alert indicator.
REQ-013 SHALL have port alert_active  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port missed_count  output  4  number of escalations, saturating.

Function
REQ-015 ack_n and snooze_n SHALL each pass through a 2-FF synchronizer, then a debouncer that changes its accepted level only after DEB_CYCLES consecutive cycles of an unchanged synchronized level.
REQ-016 A press event SHALL be a one-cycle pulse on each high-to-low transition of the debounced level; holding a button SHALL produce exactly one event.
REQ-017 remind SHALL be edge-detected; a remind event is one cycle with remind=1 when remind was 0 on the previous cycle.
REQ-018 Tick counter SHALL count 0..TICK_DIV-1, pulse tick for one cycle at TICK_DIV-1, wrap to 0, and clear to 0 on every state transition.
REQ-019 Tone SHALL be a free-running square wave toggling every BEEP_DIV cycles.
REQ-020 beat SHALL be set to 1 on every state transition and toggle on each tick.
REQ-021 Second counter SHALL clear on every state transition and increment on each tick.
REQ-022 States SHALL be IDLE, ALERT, SNOOZE, ESCALATE.
REQ-023 In IDLE: buzzer=0, led=0; remind event -> ALERT; button events ignored.
REQ-024 In ALERT: led=1, buzzer=tone AND beat; ack event -> IDLE; else snooze event -> SNOOZE; else second counter reaching ESC_SEC -> ESCALATE, with missed_count incremented on that same cycle.
REQ-025 In SNOOZE: led=beat, buzzer=0; ack event -> IDLE; else second counter reaching SNOOZE_SEC -> ALERT; snooze and remind events ignored.
REQ-026 In ESCALATE: led=1, buzzer=tone continuously; ack event -> IDLE; else snooze event -> SNOOZE; no timeout.
REQ-027 Priority on the same cycle SHALL be ack, then snooze, then timeout.
REQ-028 remind events outside IDLE SHALL be ignored, not queued.
REQ-029 missed_count SHALL saturate at 15 and clear only on reset.
REQ-030 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, buzzer=0, led=0, alert_active=0, and missed_count=0.
REQ-032 reset=1 SHALL immediately clear all counters, beat and tone to 0.
REQ-033 reset=1 SHALL set synchronizer and debounced levels to 1 (released), so no press event follows reset release.
REQ-034 Reset asserted mid-ALERT, mid-SNOOZE or mid-ESCALATE SHALL abort to IDLE with no residual buzzer output.

Verification (TICK_DIV=10, BEEP_DIV=2, DEB_CYCLES=3, ESC_SEC=3, SNOOZE_SEC=4)
REQ-035 Pulse remind 0->1 -> alert_active=1 and led=1 the next cycle; buzzer toggles every 2 cycles during the first 10 cycles, then is 0 for 10 cycles.
REQ-036 remind held with no buttons -> ESCALATE 30 cycles after entering ALERT; missed_count=1; buzzer toggles continuously; 17 such escalations -> missed_count stays 15.
REQ-037 In ALERT, hold snooze_n low for 10 cycles -> one SNOOZE entry and buzzer=0; 40 cycles later returns to ALERT; a 2-cycle ack_n glitch is rejected.
REQ-038 ack_n and snooze_n debounced presses land on the same cycle in ESCALATE -> IDLE, not SNOOZE.
REQ-039 Assert reset mid-SNOOZE with buttons held low, then release -> all outputs 0 and no state change until a new remind edge.
